edge_latency_meter: RTL and testbench
=====================================

# edge_latency_meter

Measures, in `clk` cycles, the delay between a stimulus rising edge (the divided-clock counter's output pulse driven to the board under test) and the board's response rising edge. Sits directly downstream of the counter/clock-divider stimulus path on the 100 MHz system clock. Each measurement is delivered through a valid/ready result port, with timeout, overrun and min/max statistics.

## Interface
- `CNTW`, 24: latency counter and result width; must satisfy 2^CNTW > `TIMEOUT`.
- `TIMEOUT`, 1000000: cycles to wait for a response before reporting a timeout (10 ms at 100 MHz).
- `SYNC_STAGES`, 2: synchronizer depth on `stim` and `resp`, minimum 2.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `stim`  in  1  stimulus pulse, asynchronous to `clk`.
- `resp`  in  1  response from the board under test, asynchronous.
- `clear_stats`  in  1  one-cycle clear of min/max/overrun.
- `result_ready`  in  1  consumer accepts the result.
- `result_valid`  out  1  a result is held.
- `result_latency`  out  CNTW  measured cycles.
- `result_timeout`  out  1  the result is a timeout.
- `busy`  out  1  state is not IDLE.
- `overrun_cnt`  out  8  saturating count of dropped stimulus edges.
- `min_latency`, `max_latency`  out  CNTW  statistics; present only with `LATENCY_MINMAX_EN`.

## Operation
- Both inputs pass through `SYNC_STAGES` flops, then a rising-edge detector.
- Edge detection is suppressed until `SYNC_STAGES`+1 cycles after reset release, so a level already high at release is never an edge.
- States: IDLE, ARMED, REPORT.
- **IDLE:**
  - A stim edge → ARMED with count=0.
  - A stim and resp edge detected in the same cycle → REPORT with latency 0.
- **ARMED:**
  - The count increments every cycle.
  - A resp edge in cycle N after stim detection → latch latency=N, timeout=0, go to REPORT.
  - If the count reaches `TIMEOUT` first → latency=`TIMEOUT`, timeout=1, go to REPORT.
- **REPORT:**
  - `result_valid`=1, and the outputs are held stable until `result_ready`=1, then → IDLE.
  - Resp edges are ignored.
- A stim edge seen in ARMED or REPORT is dropped; `overrun_cnt` increments and saturates at 255.
- Statistics update on REPORT entry for non-timeout results only: min=min(min,latency), max=max(max,latency).
- `clear_stats` sets min=all-ones, max=0, overrun=0. When a clear and an update land in the same cycle, the clear wins.
- `reset` mid-measurement abandons it: state=IDLE and any pending result is discarded.

## Timing
- Reset values:
  - state IDLE
  - `result_valid` 0, `result_latency` 0, `result_timeout` 0
  - `busy` 0, `overrun_cnt` 0
  - `min_latency` all-ones, `max_latency` 0
  - synchronizer flops 0
- Input-to-detect delay is `SYNC_STAGES`+1 cycles. It is identical on both paths, so it cancels in the latency figure.
- `result_valid` rises 1 cycle after the resp edge is detected, or after the timeout count.
- `busy` rises 1 cycle after stim detection.
- Handshake: a transfer occurs on a cycle with `result_valid`&&`result_ready`. A stim edge detected in that same cycle counts as overrun, not a new measurement. The earliest next measurement starts the following cycle.
- `result_ready` high while not valid has no effect.
- The counter never wraps; ARMED exits at `TIMEOUT`.

## Configuration
- `LATENCY_MINMAX_EN` defined: min/max registers and the `min_latency`/`max_latency` ports exist as described.
- Not defined: the registers and ports are absent, and `clear_stats` clears only `overrun_cnt`.
- All other behaviour is identical in both builds.

## Structure
- Shared package `latency_pkg` holds:
  - the state enum (IDLE/ARMED/REPORT)
  - the default `CNTW` and `TIMEOUT` constants
  - the `OVERRUN_MAX`=255 constant
- One sub-module: `sync_edge`, parameterised by `SYNC_STAGES`. It contains the synchronizer, the post-reset priming counter and the rising-edge detector, and is instantiated twice (stim, resp).

## Test plan
- Stim rise, resp rise 37 cycles later, `result_ready` held 1 → `result_valid` one cycle, latency=37, timeout=0, min=max=37.
- Stim rise with no resp, `TIMEOUT`=100 → latency=100, timeout=1, min/max unchanged.
- Three measurements of 20, 5, 50 cycles with the macro defined → min=5, max=50; after `clear_stats`, min=all-ones, max=0.
- `result_ready` held 0 for 30 cycles while 3 stim edges arrive → result stays stable, `overrun_cnt`=3. After 300 dropped edges → `overrun_cnt`=255.
- `stim` and `resp` both high before reset release → no measurement and `busy`=0. Reset asserted in ARMED → IDLE next cycle, `result_valid`=0.
- Stim and resp rising in the same cycle → latency=0, timeout=0.

Source files
------------

// File: rtl/latency_pkg.sv
// Shared types and constants for the edge latency meter.
package latency_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int         DEF_CNTW    = 24;
    localparam int         DEF_TIMEOUT = 1000000;
    localparam logic [7:0] OVERRUN_MAX = 8'd255;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// The detector is held off until the chain has refilled after reset.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic edge_o
);

    localparam int            PW         = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [PW-1:0]          prime_q, prime_d;
    logic                   edge_q, edge_d;
    logic                   primed;

    always_comb begin
        primed  = (prime_q == PRIME_DONE);
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        prev_d  = sync_q[SYNC_STAGES-1];
        prime_d = primed ? prime_q : prime_q + PW'(1);
        // A level already high at reset release never counts as an edge.
        edge_d  = sync_q[SYNC_STAGES-1] & ~prev_q & primed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prime_q <= '0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/edge_latency_meter.sv
// Measures clk cycles from a stim rising edge to the following resp rising edge.
// Optional min/max statistics are built when LATENCY_MINMAX_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a stim edge
// ST_ARMED  | counting cycles until a resp edge or the timeout
// ST_REPORT | result held on the valid/ready port until accepted
module edge_latency_meter
    import latency_pkg::*;
#(
    parameter int CNTW        = DEF_CNTW,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stim,
    input  logic            resp,
    input  logic            clear_stats,
    input  logic            result_ready,
    output logic            result_valid,
    output logic [CNTW-1:0] result_latency,
    output logic            result_timeout,
    output logic            busy,
    output logic [7:0]      overrun_cnt
`ifdef LATENCY_MINMAX_EN
    ,
    output logic [CNTW-1:0] min_latency,
    output logic [CNTW-1:0] max_latency
`endif
);

    localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

    logic            stim_edge, resp_edge;
    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] lat_q, lat_d;
    logic            to_q, to_d;
    logic [7:0]      ovr_q, ovr_d;
    logic [CNTW-1:0] cnt_inc;
    logic            drop;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stim (
        .clk    (clk),
        .reset  (reset),
        .din    (stim),
        .edge_o (stim_edge)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_resp (
        .clk    (clk),
        .reset  (reset),
        .din    (resp),
        .edge_o (resp_edge)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        to_d    = to_q;
        drop    = 1'b0;
        cnt_inc = cnt_q + CNTW'(1);

        case (state_q)
            ST_IDLE: begin
                if (stim_edge && resp_edge) begin
                    state_d = ST_REPORT;
                    lat_d   = '0;
                    to_d    = 1'b0;
                end else if (stim_edge) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                cnt_d = cnt_inc;
                drop  = stim_edge;
                // A response on the final cycle still counts as a real result.
                if (resp_edge) begin
                    state_d = ST_REPORT;
                    lat_d   = cnt_inc;
                    to_d    = 1'b0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = ST_REPORT;
                    lat_d   = TIMEOUT_C;
                    to_d    = 1'b1;
                end
            end
            ST_REPORT: begin
                drop = stim_edge;
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_stats) begin
            ovr_d = '0;
        end else if (drop && (ovr_q != OVERRUN_MAX)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            to_q    <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            to_q    <= to_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef LATENCY_MINMAX_EN
    logic [CNTW-1:0] min_q, min_d;
    logic [CNTW-1:0] max_q, max_d;
    logic            stat_upd;

    always_comb begin
        stat_upd = (state_q != ST_REPORT) && (state_d == ST_REPORT) && !to_d;
        min_d    = min_q;
        max_d    = max_q;
        if (clear_stats) begin
            min_d = '1;
            max_d = '0;
        end else if (stat_upd) begin
            if (lat_d < min_q) min_d = lat_d;
            if (lat_d > max_q) max_d = lat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_latency = min_q;
    assign max_latency = max_q;
`endif

    assign result_valid   = (state_q == ST_REPORT);
    assign result_latency = lat_q;
    assign result_timeout = to_q;
    assign busy           = (state_q != ST_IDLE);
    assign overrun_cnt    = ovr_q;

endmodule

// File: tb/tb_edge_latency_meter.sv
// Directed bench for edge_latency_meter: vector table plus corner-case sequences.
module tb_edge_latency_meter;

    localparam int     CNTW    = 24;
    localparam int     TIMEOUT = 100;
    localparam longint ALL1    = (64'd1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset, stim, resp, clear_stats, result_ready;
    logic            result_valid, result_timeout, busy;
    logic [CNTW-1:0] result_latency;
    logic [7:0]      overrun_cnt;
`ifdef LATENCY_MINMAX_EN
    logic [CNTW-1:0] min_latency, max_latency;
`endif

    edge_latency_meter #(.CNTW(CNTW), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stim           (stim),
        .resp           (resp),
        .clear_stats    (clear_stats),
        .result_ready   (result_ready),
        .result_valid   (result_valid),
        .result_latency (result_latency),
        .result_timeout (result_timeout),
        .busy           (busy),
        .overrun_cnt    (overrun_cnt)
`ifdef LATENCY_MINMAX_EN
        ,
        .min_latency    (min_latency),
        .max_latency    (max_latency)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        @(negedge clk);
    endtask

    // Raises stim, raises resp gap cycles later (unless no_resp), waits for the result.
    task automatic measure(input int gap, input bit no_resp,
                           output int lat, output int to, output int vcyc, output bit seen);
        stim = 1'b1;
        if (!no_resp && gap == 0) resp = 1'b1;
        for (int i = 1; i <= gap; i++) begin
            step(1);
            if (!no_resp && i == gap) resp = 1'b1;
        end
        wait_valid(seen);
        lat  = int'(result_latency);
        to   = int'(result_timeout);
        vcyc = 0;
        while (result_valid && vcyc < 5) begin
            vcyc++;
            @(negedge clk);
        end
        stim = 1'b0;
        resp = 1'b0;
        step(6);
    endtask

    typedef struct {
        int     gap;
        bit     no_resp;
        int     exp_lat;
        bit     exp_to;
        longint exp_min;
        longint exp_max;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, to, vcyc;
        bit seen, ok;

        vecs[0] = '{37, 1'b0, 37,      1'b0, 37, 37};
        vecs[1] = '{20, 1'b0, 20,      1'b0, 20, 37};
        vecs[2] = '{5,  1'b0, 5,       1'b0, 5,  37};
        vecs[3] = '{50, 1'b0, 50,      1'b0, 5,  50};
        vecs[4] = '{0,  1'b0, 0,       1'b0, 0,  50};
        vecs[5] = '{99, 1'b0, 99,      1'b0, 0,  99};
        vecs[6] = '{0,  1'b1, TIMEOUT, 1'b1, 0,  99};
        vecs[7] = '{1,  1'b0, 1,       1'b0, 0,  99};

        reset = 1'b1; stim = 1'b0; resp = 1'b0; clear_stats = 1'b0; result_ready = 1'b1;
        step(4);
        @(negedge clk);
        check("rst_valid",   result_valid,   0);
        check("rst_latency", result_latency, 0);
        check("rst_timeout", result_timeout, 0);
        check("rst_busy",    busy,           0);
        check("rst_overrun", overrun_cnt,    0);
`ifdef LATENCY_MINMAX_EN
        check("rst_min", min_latency, ALL1);
        check("rst_max", max_latency, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        step(5);

        for (int v = 0; v < 8; v++) begin
            measure(vecs[v].gap, vecs[v].no_resp, lat, to, vcyc, seen);
            check($sformatf("vec%0d_seen", v),    seen, 1);
            check($sformatf("vec%0d_latency", v), lat,  vecs[v].exp_lat);
            check($sformatf("vec%0d_timeout", v), to,   vecs[v].exp_to);
            check($sformatf("vec%0d_vcycles", v), vcyc, 1);
`ifdef LATENCY_MINMAX_EN
            check($sformatf("vec%0d_min", v), min_latency, vecs[v].exp_min);
            check($sformatf("vec%0d_max", v), max_latency, vecs[v].exp_max);
`endif
        end

        pulse_clear();
        check("clr_overrun", overrun_cnt, 0);
`ifdef LATENCY_MINMAX_EN
        check("clr_min", min_latency, ALL1);
        check("clr_max", max_latency, 0);
`endif
        step(1);

        // clear_stats lands on the same cycle as a 7-cycle result's stats update
        stim = 1'b1;
        step(7);
        resp = 1'b1;
        step(3);
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        wait_valid(seen);
        check("clrwin_seen",    seen,           1);
        check("clrwin_latency", result_latency, 7);
`ifdef LATENCY_MINMAX_EN
        check("clrwin_min", min_latency, ALL1);
        check("clrwin_max", max_latency, 0);
`endif
        stim = 1'b0; resp = 1'b0;
        step(6);

        // Result held while result_ready is low; three stim edges are dropped
        result_ready = 1'b0;
        stim = 1'b1;
        step(10);
        resp = 1'b1;
        wait_valid(seen);
        check("hold_seen",    seen,           1);
        check("hold_latency", result_latency, 10);
        @(posedge clk); #1;
        resp = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            stim = ((c % 8) >= 4) && (c < 24);
            @(negedge clk);
            if (!result_valid || result_latency != 10 || result_timeout) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("hold_stable",  ok,          1);
        check("hold_overrun", overrun_cnt, 3);
        result_ready = 1'b1;
        step(1);
        result_ready = 1'b0;
        @(negedge clk);
        check("hold_drained", result_valid, 0);
        step(1);

        // 300 dropped edges saturate the overrun counter
        stim = 1'b1;
        step(3);
        resp = 1'b1;
        wait_valid(seen);
        check("sat_seen", seen, 1);
        @(posedge clk); #1;
        resp = 1'b0;
        for (int i = 0; i < 300; i++) begin
            stim = 1'b0;
            step(2);
            stim = 1'b1;
            step(2);
        end
        step(4);
        @(negedge clk);
        check("sat_overrun", overrun_cnt, 255);
        check("sat_valid",   result_valid, 1);
        @(posedge clk); #1;
        pulse_clear();
        check("sat_cleared", overrun_cnt, 0);
        result_ready = 1'b1;
        stim = 1'b0;
        step(6);
        @(negedge clk);
        check("sat_idle", busy, 0);

        // Reset mid-measurement, with both inputs high across the release
        @(posedge clk); #1;
        stim = 1'b1;
        step(10);
        @(negedge clk);
        check("armed_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        resp  = 1'b1;
        step(1);
        @(negedge clk);
        check("rstarm_busy",  busy,         0);
        check("rstarm_valid", result_valid, 0);
        step(3);
        reset = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || result_valid) ok = 1'b0;
        end
        check("high_at_release_quiet", ok, 1);
        @(posedge clk); #1;
        stim = 1'b0; resp = 1'b0;
        step(6);

        measure(12, 1'b0, lat, to, vcyc, seen);
        check("recover_seen",    seen, 1);
        check("recover_latency", lat,  12);
        check("recover_timeout", to,   0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
